// File: rtl/left_logic_shifter.sv
// Registered logical left shifter.
// A log2(N)-stage barrel network feeds the y register; any shift amount
// with a bit set at or above the stage count clears the result.
module left_logic_shifter #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] a,
    input  logic [N-1:0] shift,
    output logic [N-1:0] y
);

    // Number of barrel stages; stage k moves the data by 2^k positions.
    localparam int unsigned S = $clog2(N);

    logic         out_of_range;
    logic [N-1:0] r;
    logic [N-1:0] amt;

    // Any set shift bit beyond the barrel stages means shift >= N.
    always_comb begin
        out_of_range = |shift[N-1:S];
    end

    // Barrel network: amt is consumed one LSB per stage, so no variable
    // bit-select of shift is needed inside the loop.
    always_comb begin
        r   = a;
        amt = shift;
        for (int unsigned k = 0; k < S; k++) begin
            if (amt[0]) begin
                r = r << (2 ** k);
            end
            amt = amt >> 1;
        end
        if (out_of_range) begin
            r = '0;
        end
    end

    // Result register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y <= '0;
        end else begin
            y <= r;
        end
    end

endmodule

// File: tb/tb_left_logic_shifter.sv
// Directed bench for left_logic_shifter at N=4, plus random checks at N=8/32.
module tb_left_logic_shifter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  a4, s4, y4;
    logic [7:0]  a8, s8, y8;
    logic [31:0] a32, s32, y32;

    int checks;
    int failures;

    left_logic_shifter #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .shift(s4), .y(y4)
    );
    left_logic_shifter #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .shift(s8), .y(y8)
    );
    left_logic_shifter #(.N(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .a(a32), .shift(s32), .y(y32)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-computed tables for N=4.
    logic [3:0] t_a   [15] = '{4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001,
                               4'b1100, 4'b0110, 4'b0011, 4'b1001, 4'b1010,
                               4'b0101, 4'b1110, 4'b1101, 4'b1011, 4'b1111};
    logic [3:0] t_sh1 [15] = '{4'b0000, 4'b0000, 4'b1000, 4'b0100, 4'b0010,
                               4'b1000, 4'b1100, 4'b0110, 4'b0010, 4'b0100,
                               4'b1010, 4'b1100, 4'b1010, 4'b0110, 4'b1110};
    logic [3:0] t_sh2 [15] = '{4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0100,
                               4'b0000, 4'b1000, 4'b1100, 4'b0100, 4'b1000,
                               4'b0100, 4'b1000, 4'b0100, 4'b1100, 4'b1100};

    task automatic test_reset();
        rst_n = 1'b0;
        a4 = 4'b1111; s4 = 4'b0000;
        a8 = 8'hff;   s8 = 8'h00;
        a32 = '1;     s32 = '0;
        @(posedge clk); #1;
        checks++;
        if (y4 !== 4'b0000) begin
            failures++;
            $display("FAIL reset_y4 got=%b exp=%b", y4, 4'b0000);
        end
        checks++;
        if (y8 !== 8'h00 || y32 !== 32'h0) begin
            failures++;
            $display("FAIL reset_wide got8=%h got32=%h exp=0", y8, y32);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_shift_one();
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            a4 = t_a[i]; s4 = 4'd1;
            @(posedge clk); #1;
            checks++;
            if (y4 !== t_sh1[i]) begin
                failures++;
                $display("FAIL shift1 a=%b got=%b exp=%b", t_a[i], y4, t_sh1[i]);
            end
        end
    endtask

    task automatic test_shift_two();
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            a4 = t_a[i]; s4 = 4'd2;
            @(posedge clk); #1;
            checks++;
            if (y4 !== t_sh2[i]) begin
                failures++;
                $display("FAIL shift2 a=%b got=%b exp=%b", t_a[i], y4, t_sh2[i]);
            end
        end
    endtask

    task automatic test_boundary();
        logic [3:0] ba [4] = '{4'b1011, 4'b1011, 4'b1111, 4'b1111};
        logic [3:0] bs [4] = '{4'd0,    4'd3,    4'd4,    4'd15};
        logic [3:0] be [4] = '{4'b1011, 4'b1000, 4'b0000, 4'b0000};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a4 = ba[i]; s4 = bs[i];
            @(posedge clk); #1;
            checks++;
            if (y4 !== be[i]) begin
                failures++;
                $display("FAIL boundary a=%b s=%0d got=%b exp=%b", ba[i], bs[i], y4, be[i]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        a4 = 4'b1111; s4 = 4'd1;
        @(posedge clk); #1;
        checks++;
        if (y4 !== 4'b1110) begin
            failures++;
            $display("FAIL midreset_pre got=%b exp=%b", y4, 4'b1110);
        end
        @(negedge clk);
        rst_n = 1'b0; a4 = 4'b0101; s4 = 4'd1;
        @(posedge clk); #1;
        checks++;
        if (y4 !== 4'b0000) begin
            failures++;
            $display("FAIL midreset_clear got=%b exp=%b", y4, 4'b0000);
        end
        @(negedge clk);
        rst_n = 1'b1; a4 = 4'b0001; s4 = 4'd1;
        @(posedge clk); #1;
        checks++;
        if (y4 !== 4'b0010) begin
            failures++;
            $display("FAIL midreset_release got=%b exp=%b", y4, 4'b0010);
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        a4 = 4'b0011; s4 = 4'd1;
        @(posedge clk); #1;
        checks++;
        if (y4 !== 4'b0110) begin
            failures++;
            $display("FAIL hold_load got=%b exp=%b", y4, 4'b0110);
        end
        // Inputs and reset wiggle between edges; y must not move.
        #1 a4 = 4'b1111; s4 = 4'd0;
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        #1;
        checks++;
        if (y4 !== 4'b0110) begin
            failures++;
            $display("FAIL hold_between got=%b exp=%b", y4, 4'b0110);
        end
        @(posedge clk); #1;
        checks++;
        if (y4 !== 4'b1111) begin
            failures++;
            $display("FAIL hold_next got=%b exp=%b", y4, 4'b1111);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] va [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0110, 4'b1001};
        logic [3:0] vs [6] = '{4'd0,    4'd1,    4'd2,    4'd3,    4'd5,    4'd3};
        logic [3:0] ve [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b1000};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            a4 = va[i]; s4 = vs[i];
            @(posedge clk); #1;
            checks++;
            if (y4 !== ve[i]) begin
                failures++;
                $display("FAIL b2b step=%0d got=%b exp=%b", i, y4, ve[i]);
            end
        end
    endtask

    task automatic test_wide();
        logic [7:0]  e8;
        logic [31:0] e32;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            a8  = 8'($urandom);
            a32 = $urandom;
            case (i % 4)
                0: begin s8 = 8'($urandom_range(0, 7));  s32 = 32'($urandom_range(0, 31)); end
                1: begin s8 = 8'd7;                       s32 = 32'd31; end
                2: begin s8 = 8'($urandom_range(8, 255)); s32 = 32'($urandom_range(32, 100)); end
                default: begin s8 = 8'hff;                s32 = 32'hffff_ffff; end
            endcase
            e8  = (s8  >= 8'd8)   ? 8'h00 : (a8 << s8);
            e32 = (s32 >= 32'd32) ? 32'h0 : (a32 << s32);
            @(posedge clk); #1;
            checks++;
            if (y8 !== e8) begin
                failures++;
                $display("FAIL wide8 a=%h s=%0d got=%h exp=%h", a8, s8, y8, e8);
            end
            checks++;
            if (y32 !== e32) begin
                failures++;
                $display("FAIL wide32 a=%h s=%0d got=%h exp=%h", a32, s32, y32, e32);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n = 1'b0;
        a4 = '0; s4 = '0; a8 = '0; s8 = '0; a32 = '0; s32 = '0;
        test_reset();
        test_shift_one();
        test_shift_two();
        test_boundary();
        test_reset_midstream();
        test_hold();
        test_back_to_back();
        test_wide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
